fill_readout_sequencer: RTL and testbench
=========================================

Name: fill_readout_sequencer

Overview:
- Sits in the clk125 local domain between the DDR3 interface's fill-header FIFO and read engine, and the downstream readout consumer.
- Pops one fill header at a time and decodes address and burst count from it.
- Programs the read engine's start address and burst count, holds enable_reading until reading_done, then reports the fill as complete.
- Serializes fills and gates starts on a consumer grant and on read-FIFO backpressure.

Parameters:
- ADDR_W, 23, DDR3 burst address width.
- CNT_W, 24, burst count width.
- HDR_W, 152, fill-header FIFO width.
- WDOG_W, 24, watchdog counter width (used only when the optional feature is compiled in).

Ports:
- clk125  in  1  local user clock.
- reset_clk125_n  in  1  asynchronous active-low reset.
- fill_header_fifo_empty  in  1  no header available when high.
- fill_header_fifo_rd_en  out  1  one-cycle pop strobe.
- fill_header_fifo_out  in  HDR_W  header at FIFO head (first-word-fall-through).
- readout_grant  in  1  consumer permits the next fill to start.
- ddr3_rd_fifo_almost_full  in  1  read FIFO nearly full.
- ddr3_rd_start_addr  out  ADDR_W  first burst address.
- ddr3_rd_burst_cnt  out  CNT_W  bursts to read.
- enable_reading  out  1  read engine enable, held as a level.
- reading_done  in  1  read engine finished.
- fill_start  out  1  one-cycle pulse when a fill is launched.
- fill_done  out  1  one-cycle pulse when a fill is complete.
- cur_fill_num  out  24  fill number of the active or last fill.
- fills_read  out  32  completed-fill counter, wraps.
- zero_len_err  out  1  sticky; set when a header has burst count 0.
- seq_busy  out  1  high in every state except IDLE.

Behaviour:
- Header field layout: [22:0] start address; [46:23] burst count; [70:47] fill number; [151:71] ignored.
- Reset value of every output is 0. Asynchronous assert, synchronous release.
- An asynchronous reset mid-fill drops enable_reading immediately and returns the FSM to IDLE. Recovery of the read engine is its own reset's job.
- States:
  - IDLE: go to POP when fill_header_fifo_empty=0 and readout_grant=1.
  - POP: assert fill_header_fifo_rd_en for exactly 1 cycle. Latch address, count and fill number from fill_header_fifo_out in the same cycle. Go to CHECK.
  - CHECK: if count==0, set zero_len_err, pulse fill_done, increment fills_read, go to IDLE (no read issued). Otherwise go to ARM.
  - ARM: drive ddr3_rd_start_addr/ddr3_rd_burst_cnt from the latched values; they stay stable until the next POP. Wait while ddr3_rd_fifo_almost_full=1. When it is 0, go to READ and assert enable_reading with fill_start pulsed in the same cycle.
  - READ: hold enable_reading=1. On reading_done=1, deassert enable_reading the next cycle, go to DRAIN.
  - DRAIN: wait until reading_done=0, which guards against a stale done being seen on the next fill. Then pulse fill_done, increment fills_read, go to IDLE.
- Latency: empty-falling with grant high → rd_en on the next cycle; enable_reading 2 cycles after rd_en if not almost_full.
- A reading_done that is already high on entry to READ counts as done. The DRAIN state handles its clearing.
- Any new header arriving while busy is ignored until IDLE.
- readout_grant is sampled only in IDLE; dropping it mid-fill has no effect.
- fills_read wraps 0xFFFFFFFF → 0.
- zero_len_err clears only on reset.

Optional Feature:
- Macro: FILL_READ_WATCHDOG_EN.
- With it:
  - Adds input wdog_limit[WDOG_W-1:0] and sticky output rd_timeout_err.
  - A counter clears on READ entry and counts each cycle in READ.
  - When it reaches wdog_limit (limit 0 disables): set rd_timeout_err, drop enable_reading, pulse fill_done, go to IDLE without incrementing fills_read.
- Without it: the port and logic are absent, and READ waits indefinitely.

Decomposition:
- Shared package:
  - State enumeration.
  - Header field LSB/MSB constants (HDR_ADDR_LSB=0, HDR_CNT_LSB=23, HDR_FILL_LSB=47).
  - Widths ADDR_W/CNT_W.
- One sub-module: fill_header_decode, a registered field extractor with a load strobe that captures addr/cnt/fill_num.
- The FSM and counters remain in the top.

Test Plan:
- Single fill: header addr=0x000100, cnt=0x000040, fill=5; grant=1 → one rd_en pulse; enable_reading rises 2 cycles later with addr=0x100, cnt=0x40; reading_done after 64 cycles → fill_done pulse, fills_read=1, cur_fill_num=5.
- Backpressure: almost_full=1 in ARM for 20 cycles → enable_reading stays 0 for those 20 cycles, rises the cycle after almost_full falls.
- Zero length: header cnt=0 → zero_len_err=1, enable_reading never asserted, fill_done pulsed, fills_read increments; the next valid header still processes.
- Back-to-back: 3 headers queued, reading_done held high 4 cycles each time → exactly 3 fill_start and 3 fill_done pulses, no duplicate read, fills_read=3.
- Reset mid-READ: drive reset_clk125_n low → enable_reading=0 the same cycle, all outputs 0; after release, the pending header is popped normally.
- Watchdog (FILL_READ_WATCHDOG_EN): wdog_limit=100, reading_done never asserted → rd_timeout_err=1 at cycle 100 of READ, FSM in IDLE, fills_read unchanged.

Source files
------------

// File: rtl/fill_readout_sequencer_pkg.sv
// rtl/fill_readout_sequencer_pkg.sv - shared types and header layout for the fill readout sequencer
//
// Purpose: FSM state enumeration, field widths and the bit positions of the
// fill header fields, shared by the sequencer top and its header decoder.
// Ports: none (package).

package fill_readout_sequencer_pkg;

    localparam int ADDR_W       = 23;
    localparam int CNT_W        = 24;
    localparam int FILL_W       = 24;

    localparam int HDR_ADDR_LSB = 0;
    localparam int HDR_CNT_LSB  = 23;
    localparam int HDR_FILL_LSB = 47;
    // First header bit above the fields we decode; everything from here up is ignored.
    localparam int HDR_USED_W   = HDR_FILL_LSB + FILL_W;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_POP   = 3'd1,
        ST_CHECK = 3'd2,
        ST_ARM   = 3'd3,
        ST_READ  = 3'd4,
        ST_DRAIN = 3'd5
    } seq_state_t;

endpackage

// File: rtl/fill_readout_sequencer_decode.sv
// rtl/fill_readout_sequencer_decode.sv - registered fill header field extractor
//
// Purpose: captures start address, burst count and fill number from the header
// at the FIFO head when load is high; holds them until the next load.
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   load            capture strobe (one cycle, aligned with the FIFO pop)
//   hdr[HDR_W]      header word at the FIFO head
//   addr[ADDR_W]    latched first burst address
//   cnt[CNT_W]      latched burst count
//   fill_num[FILL_W] latched fill number

module fill_header_decode
    import fill_readout_sequencer_pkg::*;
#(
    parameter int HDR_W = 152
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [HDR_W-1:0]  hdr,
    output logic [ADDR_W-1:0] addr,
    output logic [CNT_W-1:0]  cnt,
    output logic [FILL_W-1:0] fill_num
);

    // Upper header bits carry nothing this block needs.
    logic hdr_unused;
    assign hdr_unused = ^hdr[HDR_W-1:HDR_USED_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr     <= '0;
            cnt      <= '0;
            fill_num <= '0;
        end else if (load) begin
            addr     <= hdr[HDR_ADDR_LSB +: ADDR_W];
            cnt      <= hdr[HDR_CNT_LSB +: CNT_W];
            fill_num <= hdr[HDR_FILL_LSB +: FILL_W];
        end
    end

endmodule

// File: rtl/fill_readout_sequencer.sv
// rtl/fill_readout_sequencer.sv - pops fill headers and sequences one DDR3 read per fill
//
// Purpose: one fill at a time, pop a header, program the read engine, hold
// enable_reading until reading_done, then report the fill complete.
// Optional feature macro: FILL_READ_WATCHDOG_EN (bounded READ with timeout error).
// Ports:
//   clk125, reset_clk125_n                clock, asynchronous active-low reset
//   fill_header_fifo_empty/_rd_en/_out    fill-header FIFO (first-word-fall-through)
//   readout_grant                         consumer permits the next fill (sampled in IDLE)
//   ddr3_rd_fifo_almost_full              read FIFO backpressure, holds the launch
//   ddr3_rd_start_addr, ddr3_rd_burst_cnt read engine programming
//   enable_reading, reading_done          read engine handshake
//   fill_start, fill_done                 one-cycle launch / completion pulses
//   cur_fill_num, fills_read              fill number of active/last fill, completed count
//   zero_len_err                          sticky: a header had burst count 0
//   seq_busy                              high outside IDLE
//   wdog_limit, rd_timeout_err            (FILL_READ_WATCHDOG_EN only) READ cycle limit, sticky timeout

module fill_readout_sequencer
    import fill_readout_sequencer_pkg::*;
#(
    parameter int HDR_W = 152
`ifdef FILL_READ_WATCHDOG_EN
    ,
    parameter int WDOG_W = 24
`endif
) (
    input  logic              clk125,
    input  logic              reset_clk125_n,
    input  logic              fill_header_fifo_empty,
    output logic              fill_header_fifo_rd_en,
    input  logic [HDR_W-1:0]  fill_header_fifo_out,
    input  logic              readout_grant,
    input  logic              ddr3_rd_fifo_almost_full,
    output logic [ADDR_W-1:0] ddr3_rd_start_addr,
    output logic [CNT_W-1:0]  ddr3_rd_burst_cnt,
    output logic              enable_reading,
    input  logic              reading_done,
    output logic              fill_start,
    output logic              fill_done,
    output logic [FILL_W-1:0] cur_fill_num,
    output logic [31:0]       fills_read,
    output logic              zero_len_err,
    output logic              seq_busy
`ifdef FILL_READ_WATCHDOG_EN
    ,
    input  logic [WDOG_W-1:0] wdog_limit,
    output logic              rd_timeout_err
`endif
);

    seq_state_t state, state_next;
    logic       zero_hit;
    logic       count_fill;
    logic       read_abort;

    // Decoded fields double as the read engine programming: they change only
    // at the end of POP, so they are stable for the whole ARM/READ/DRAIN span.
    fill_header_decode #(
        .HDR_W (HDR_W)
    ) u_decode (
        .clk      (clk125),
        .rst_n    (reset_clk125_n),
        .load     (fill_header_fifo_rd_en),
        .hdr      (fill_header_fifo_out),
        .addr     (ddr3_rd_start_addr),
        .cnt      (ddr3_rd_burst_cnt),
        .fill_num (cur_fill_num)
    );

`ifdef FILL_READ_WATCHDOG_EN
    logic [WDOG_W-1:0] wdog_cnt;
    logic              wdog_hit;

    // wdog_cnt holds (READ cycle index - 1), so the hit lands on READ cycle wdog_limit.
    assign wdog_hit   = (state == ST_READ) && (wdog_limit != '0) &&
                        ((wdog_cnt + 1'b1) == wdog_limit);
    assign read_abort = wdog_hit;

    always_ff @(posedge clk125 or negedge reset_clk125_n) begin
        if (!reset_clk125_n) begin
            wdog_cnt       <= '0;
            rd_timeout_err <= 1'b0;
        end else begin
            if (fill_start) begin
                wdog_cnt <= '0;
            end else if (state == ST_READ) begin
                wdog_cnt <= wdog_cnt + 1'b1;
            end
            // A done arriving on the limit cycle wins; the fill completes normally.
            if (wdog_hit && !reading_done) begin
                rd_timeout_err <= 1'b1;
            end
        end
    end
`else
    assign read_abort = 1'b0;
`endif

    always_ff @(posedge clk125 or negedge reset_clk125_n) begin
        if (!reset_clk125_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // enable_reading and fill_start depend combinationally on almost_full in
    // ARM so the read engine starts two cycles after the pop when unblocked.
    always_comb begin
        state_next             = state;
        fill_header_fifo_rd_en = 1'b0;
        enable_reading         = 1'b0;
        fill_start             = 1'b0;
        fill_done              = 1'b0;
        zero_hit               = 1'b0;
        count_fill             = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!fill_header_fifo_empty && readout_grant) begin
                    state_next = ST_POP;
                end
            end
            ST_POP: begin
                fill_header_fifo_rd_en = 1'b1;
                state_next             = ST_CHECK;
            end
            ST_CHECK: begin
                if (ddr3_rd_burst_cnt == '0) begin
                    zero_hit   = 1'b1;
                    fill_done  = 1'b1;
                    count_fill = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    state_next = ST_ARM;
                end
            end
            ST_ARM: begin
                if (!ddr3_rd_fifo_almost_full) begin
                    enable_reading = 1'b1;
                    fill_start     = 1'b1;
                    state_next     = ST_READ;
                end
            end
            ST_READ: begin
                enable_reading = 1'b1;
                if (reading_done) begin
                    state_next = ST_DRAIN;
                end else if (read_abort) begin
                    enable_reading = 1'b0;
                    fill_done      = 1'b1;
                    state_next     = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                // Wait for done to fall so the next fill cannot see a stale done.
                if (!reading_done) begin
                    fill_done  = 1'b1;
                    count_fill = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign seq_busy = (state != ST_IDLE);

    always_ff @(posedge clk125 or negedge reset_clk125_n) begin
        if (!reset_clk125_n) begin
            fills_read   <= '0;
            zero_len_err <= 1'b0;
        end else begin
            if (count_fill) begin
                fills_read <= fills_read + 32'd1;
            end
            if (zero_hit) begin
                zero_len_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fill_readout_sequencer.sv
// tb/tb_fill_readout_sequencer.sv - self-checking bench for fill_readout_sequencer

module tb_fill_readout_sequencer;

    logic         clk125 = 1'b0;
    logic         reset_clk125_n;
    logic         fill_header_fifo_empty;
    logic         fill_header_fifo_rd_en;
    logic [151:0] fill_header_fifo_out;
    logic         readout_grant;
    logic         ddr3_rd_fifo_almost_full;
    logic [22:0]  ddr3_rd_start_addr;
    logic [23:0]  ddr3_rd_burst_cnt;
    logic         enable_reading;
    logic         reading_done;
    logic         fill_start;
    logic         fill_done;
    logic [23:0]  cur_fill_num;
    logic [31:0]  fills_read;
    logic         zero_len_err;
    logic         seq_busy;
`ifdef FILL_READ_WATCHDOG_EN
    logic [23:0]  wdog_limit;
    logic         rd_timeout_err;
`endif

    fill_readout_sequencer dut (
        .clk125                   (clk125),
        .reset_clk125_n           (reset_clk125_n),
        .fill_header_fifo_empty   (fill_header_fifo_empty),
        .fill_header_fifo_rd_en   (fill_header_fifo_rd_en),
        .fill_header_fifo_out     (fill_header_fifo_out),
        .readout_grant            (readout_grant),
        .ddr3_rd_fifo_almost_full (ddr3_rd_fifo_almost_full),
        .ddr3_rd_start_addr       (ddr3_rd_start_addr),
        .ddr3_rd_burst_cnt        (ddr3_rd_burst_cnt),
        .enable_reading           (enable_reading),
        .reading_done             (reading_done),
        .fill_start               (fill_start),
        .fill_done                (fill_done),
        .cur_fill_num             (cur_fill_num),
        .fills_read               (fills_read),
        .zero_len_err             (zero_len_err),
        .seq_busy                 (seq_busy)
`ifdef FILL_READ_WATCHDOG_EN
        ,
        .wdog_limit               (wdog_limit),
        .rd_timeout_err           (rd_timeout_err)
`endif
    );

    always #5 clk125 = ~clk125;

    int checks = 0;
    int errors = 0;

    // Header FIFO model: head word presented first-word-fall-through.
    logic [151:0] hq[$];

    // Per-cycle samples taken mid-cycle.
    logic s_rd_en, s_en, s_start, s_done, s_busy;
    int   n_start = 0;
    int   n_done  = 0;
    int   wait_cycles;

    // Reference expectations.
    logic [31:0] exp_fills = '0;
    logic        exp_zero  = 1'b0;
    logic [23:0] exp_fill  = '0;

    initial begin
        #5ms;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [151:0] rand152();
        logic [159:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return r[151:0];
    endfunction

    function automatic logic [151:0] mk_hdr(input logic [22:0] a, input logic [23:0] c,
                                            input logic [23:0] f);
        logic [151:0] h;
        h = rand152();
        h[22:0]  = a;
        h[46:23] = c;
        h[70:47] = f;
        return h;
    endfunction

    task automatic fifo_refresh();
        fill_header_fifo_empty = (hq.size() == 0);
        if (hq.size() > 0) fill_header_fifo_out = hq[0];
        else               fill_header_fifo_out = rand152();
    endtask

    task automatic push(input logic [151:0] h);
        hq.push_back(h);
        fifo_refresh();
    endtask

    // One clock: sample mid-cycle, then pop the FIFO model if rd_en was seen.
    task automatic step();
        @(negedge clk125);
        s_rd_en = fill_header_fifo_rd_en;
        s_en    = enable_reading;
        s_start = fill_start;
        s_done  = fill_done;
        s_busy  = seq_busy;
        n_start += int'(s_start);
        n_done  += int'(s_done);
        @(posedge clk125);
        #1;
        if (s_rd_en && hq.size() > 0) hq.delete(0);
        fifo_refresh();
    endtask

    task automatic chk_zero_outputs();
        chk("rst_rd_en", fill_header_fifo_rd_en, 0);
        chk("rst_addr", ddr3_rd_start_addr, 0);
        chk("rst_cnt", ddr3_rd_burst_cnt, 0);
        chk("rst_en", enable_reading, 0);
        chk("rst_start", fill_start, 0);
        chk("rst_done", fill_done, 0);
        chk("rst_fill_num", cur_fill_num, 0);
        chk("rst_fills_read", fills_read, 0);
        chk("rst_zero_err", zero_len_err, 0);
        chk("rst_busy", seq_busy, 0);
`ifdef FILL_READ_WATCHDOG_EN
        chk("rst_timeout_err", rd_timeout_err, 0);
`endif
    endtask

    // Runs the fill at the FIFO head from IDLE to completion and checks its timeline.
    task automatic serve_fill(input int af_cycles, input int done_delay, input int done_hold);
        logic [151:0] h;
        logic [22:0]  a;
        logic [23:0]  c;
        logic [23:0]  f;
        int           n;
        if (hq.size() == 0) begin
            chk("queue_nonempty", 0, 1);
            return;
        end
        h = hq[0];
        a = h[22:0];
        c = h[46:23];
        f = h[70:47];
        readout_grant            = 1'b1;
        ddr3_rd_fifo_almost_full = (af_cycles > 0);
        reading_done             = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (!s_rd_en && n < 20);
        wait_cycles = n;
        chk("rd_en_pulse", s_rd_en, 1);
        step();
        chk("rd_en_single", s_rd_en, 0);
        chk("check_no_en", s_en, 0);
        if (c == 24'd0) begin
            chk("zero_done_pulse", s_done, 1);
            exp_fills = exp_fills + 32'd1;
            exp_zero  = 1'b1;
            exp_fill  = f;
            step();
            chk("zero_no_en", s_en, 0);
        end else begin
            chk("check_no_done", s_done, 0);
            for (int i = 0; i < af_cycles; i++) begin
                step();
                chk("bp_en_low", s_en, 0);
                chk("bp_no_start", s_start, 0);
            end
            ddr3_rd_fifo_almost_full = 1'b0;
            step();
            chk("start_pulse", s_start, 1);
            chk("en_rise", s_en, 1);
            chk("start_addr", ddr3_rd_start_addr, a);
            chk("burst_cnt", ddr3_rd_burst_cnt, c);
            for (int i = 0; i < done_delay; i++) begin
                readout_grant = 1'($urandom_range(0, 1));
                step();
                chk("read_en_held", s_en, 1);
                chk("read_no_done", s_done, 0);
                chk("read_no_pop", s_rd_en, 0);
                chk("read_no_restart", s_start, 0);
                chk("addr_stable", ddr3_rd_start_addr, a);
            end
            reading_done = 1'b1;
            step();
            chk("done_seen_en", s_en, 1);
            chk("done_seen_no_done", s_done, 0);
            for (int j = 1; j < done_hold; j++) begin
                step();
                chk("drain_en_low", s_en, 0);
                chk("drain_no_done", s_done, 0);
                chk("drain_no_pop", s_rd_en, 0);
            end
            reading_done  = 1'b0;
            readout_grant = 1'b1;
            step();
            chk("fill_done_pulse", s_done, 1);
            chk("fill_done_en_low", s_en, 0);
            exp_fills = exp_fills + 32'd1;
            exp_fill  = f;
            step();
            chk("idle_en_low", s_en, 0);
        end
        chk("idle_not_busy", s_busy, 0);
        chk("fills_read", fills_read, exp_fills);
        chk("zero_len_err", zero_len_err, exp_zero);
        chk("cur_fill_num", cur_fill_num, exp_fill);
    endtask

    initial begin
        int n;
        int s0;
        int d0;
        reset_clk125_n           = 1'b0;
        readout_grant            = 1'b0;
        ddr3_rd_fifo_almost_full = 1'b0;
        reading_done             = 1'b0;
`ifdef FILL_READ_WATCHDOG_EN
        wdog_limit               = '0;
`endif
        fifo_refresh();
        step();
        step();
        chk_zero_outputs();
        reset_clk125_n = 1'b1;
        step();

        // Grant low holds off the pop; then the single reference fill.
        push(mk_hdr(23'h000100, 24'h000040, 24'd5));
        repeat (4) begin
            step();
            chk("no_grant_no_pop", s_rd_en, 0);
            chk("no_grant_idle", s_busy, 0);
        end
        serve_fill(0, 63, 1);
        chk("single_pop_latency", wait_cycles, 2);
        chk("single_fill_num", cur_fill_num, 24'd5);

        // Backpressure for 20 ARM cycles.
        push(mk_hdr(23'h012345, 24'd9, 24'd6));
        serve_fill(20, 3, 2);
        chk("bp_pop_latency", wait_cycles, 2);

        // Zero-length header followed by a valid one.
        push(mk_hdr(23'h000777, 24'd0, 24'd7));
        push(mk_hdr(23'h000888, 24'd2, 24'd8));
        serve_fill(0, 0, 1);
        serve_fill(0, 1, 1);

        // Back-to-back, done held 4 cycles each.
        s0 = n_start;
        d0 = n_done;
        push(mk_hdr(23'h100000, 24'd4, 24'd10));
        push(mk_hdr(23'h200000, 24'd5, 24'd11));
        push(mk_hdr(23'h300000, 24'd6, 24'd12));
        serve_fill(0, 0, 4);
        serve_fill(0, 0, 4);
        chk("b2b_next_pop", wait_cycles, 1);
        serve_fill(0, 0, 4);
        chk("b2b_starts", n_start - s0, 3);
        chk("b2b_dones", n_done - d0, 3);

        // Randomized fills.
        for (int k = 0; k < 10; k++) begin
            logic [23:0] c;
            c = ($urandom_range(0, 3) == 0) ? 24'd0 : 24'($urandom_range(1, 200));
            push(mk_hdr(23'($urandom), c, 24'($urandom)));
            serve_fill(int'($urandom_range(0, 5)), int'($urandom_range(0, 6)),
                       int'($urandom_range(1, 4)));
        end

        // Reset in the middle of READ, with a second header pending.
        push(mk_hdr(23'h070000, 24'd8, 24'd77));
        push(mk_hdr(23'h001234, 24'd3, 24'd78));
        readout_grant            = 1'b1;
        ddr3_rd_fifo_almost_full = 1'b0;
        reading_done             = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (!s_start && n < 20);
        chk("rst_pre_start", s_start, 1);
        repeat (3) step();
        reset_clk125_n = 1'b0;
        #1;
        chk("rst_en_drop_now", enable_reading, 0);
        chk_zero_outputs();
        exp_fills = '0;
        exp_zero  = 1'b0;
        exp_fill  = '0;
        step();
        step();
        reset_clk125_n = 1'b1;
        serve_fill(0, 2, 1);
        chk("rst_pending_pop_latency", wait_cycles, 2);
        chk("rst_pending_fill", cur_fill_num, 24'd78);

`ifdef FILL_READ_WATCHDOG_EN
        wdog_limit = 24'd100;
        push(mk_hdr(23'h002222, 24'd16, 24'd99));
        readout_grant = 1'b1;
        reading_done  = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (!s_start && n < 20);
        chk("wd_start", s_start, 1);
        for (int k = 1; k <= 100; k++) begin
            step();
            if (k < 100) begin
                chk("wd_en_held", s_en, 1);
                chk("wd_no_done", s_done, 0);
            end else begin
                chk("wd_done_pulse", s_done, 1);
            end
        end
        step();
        chk("wd_timeout_err", rd_timeout_err, 1);
        chk("wd_idle", s_busy, 0);
        chk("wd_en_low", s_en, 0);
        chk("wd_fills_unchanged", fills_read, exp_fills);
        wdog_limit = '0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
